// File: rtl/signed_divide.sv
// Signed A/B restoring divider (truncating Q, R takes dividend sign), one quotient bit per clock.
// Latency A_WIDTH+1 cycles (1 for /0 and min/-1); in_ready low while busy, extra in_valid is dropped.
module signed_divide #(
  parameter int A_WIDTH = 24,
  parameter int B_WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_A,
  input  logic [B_WIDTH-1:0] in_B,
  output logic               out_valid,
  output logic [A_WIDTH-1:0] out_Q,
  output logic [B_WIDTH-1:0] out_R,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = $clog2(A_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] a_sh;
  logic [B_WIDTH-1:0] b_mag;
  logic [B_WIDTH-1:0] p_rem;
  logic [CW-1:0]      cnt;
  logic               sign_q, sign_r, dbz_pend, ovf_pend;

  logic               b_zero, a_min, b_neg1, special, last, fits;
  logic [A_WIDTH-1:0] a_abs;
  logic [B_WIDTH-1:0] b_abs;
  logic [B_WIDTH:0]   trial;

  assign b_zero  = (in_B == '0);
  assign a_min   = (in_A == {1'b1, {(A_WIDTH-1){1'b0}}});
  assign b_neg1  = (in_B == '1);
  assign special = b_zero || (a_min && b_neg1);
  assign a_abs   = in_A[A_WIDTH-1] ? -in_A : in_A;
  assign b_abs   = in_B[B_WIDTH-1] ? -in_B : in_B;
  assign last    = (cnt == CW'(A_WIDTH-1));

  // Partial remainder stays below |B|, so B_WIDTH bits hold it; only the trial needs one more.
  assign trial   = {p_rem, a_sh[A_WIDTH-1]};
  assign fits    = (trial >= {1'b0, b_mag});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = special ? FIX : BUSY;
      end
      BUSY:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh        <= '0;
      b_mag       <= '0;
      p_rem       <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz_pend    <= 1'b0;
      ovf_pend    <= 1'b0;
      out_valid   <= 1'b0;
      out_Q       <= '0;
      out_R       <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            p_rem <= '0;
            // Special results are preloaded as an unsigned magnitude so FIX needs no extra path.
            if (b_zero) begin
              a_sh     <= '1;
              sign_q   <= 1'b0;
              sign_r   <= 1'b0;
              dbz_pend <= 1'b1;
              ovf_pend <= 1'b0;
            end else if (a_min && b_neg1) begin
              a_sh     <= in_A;
              sign_q   <= 1'b0;
              sign_r   <= 1'b0;
              dbz_pend <= 1'b0;
              ovf_pend <= 1'b1;
            end else begin
              a_sh     <= a_abs;
              b_mag    <= b_abs;
              sign_q   <= in_A[A_WIDTH-1] ^ in_B[B_WIDTH-1];
              sign_r   <= in_A[A_WIDTH-1];
              dbz_pend <= 1'b0;
              ovf_pend <= 1'b0;
            end
          end
        end
        BUSY: begin
          p_rem <= fits ? (trial[B_WIDTH-1:0] - b_mag) : trial[B_WIDTH-1:0];
          a_sh  <= {a_sh[A_WIDTH-2:0], fits};
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          out_Q       <= sign_q ? -a_sh : a_sh;
          out_R       <= sign_r ? -p_rem : p_rem;
          div_by_zero <= dbz_pend;
          overflow    <= ovf_pend;
          out_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divide.sv
// Scoreboard bench for signed_divide: an 8/8 and a 12/6 instance, directed vectors plus model-checked sweeps.
module tb_signed_divide;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v8, rdy8, ov8, dz8, of8;
  logic [7:0]  a8, b8, q8, r8;
  logic        v12, rdy12, ov12, dz12, of12;
  logic [11:0] a12, q12;
  logic [5:0]  b12, r12;

  signed_divide #(.A_WIDTH(8), .B_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_A(a8), .in_B(b8),
    .out_valid(ov8), .out_Q(q8), .out_R(r8), .div_by_zero(dz8), .overflow(of8));

  signed_divide #(.A_WIDTH(12), .B_WIDTH(6)) dut12 (
    .clk(clk), .reset(reset), .in_valid(v12), .in_ready(rdy12), .in_A(a12), .in_B(b12),
    .out_valid(ov12), .out_Q(q12), .out_R(r12), .div_by_zero(dz12), .overflow(of12));

  typedef struct {
    int q;
    int r;
    bit dz;
    bit of;
    int acc;
    int lat;
  } exp_t;

  exp_t sb8[$];
  exp_t sb12[$];
  exp_t e8, e12;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t model(input int a, input int b, input int aw);
    exp_t m;
    m = '{0, 0, 1'b0, 1'b0, 0, 0};
    if (b == 0) begin
      m.q = -1; m.dz = 1'b1;
    end else if (a == -(1 << (aw - 1)) && b == -1) begin
      m.q = a; m.of = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b;
    end
    return m;
  endfunction

  function automatic bit rdy(input int w);
    return (w == 8) ? rdy8 : rdy12;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input int w, input int a, input int b, input int q, input int r,
                       input bit dz, input bit of);
    int   n;
    exp_t e;
    n = 0;
    while (!rdy(w) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!rdy(w)) begin
      bad("issue_wait_ready_timeout");
      return;
    end
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; v8 = 1'b1;
    end else begin
      a12 = a[11:0]; b12 = b[5:0]; v12 = 1'b1;
    end
    @(posedge clk); #1;
    v8 = 1'b0; v12 = 1'b0;
    e = '{q, r, dz, of, cyc, (dz || of) ? 1 : w + 1};
    if (w == 8) sb8.push_back(e);
    else        sb12.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb8.size() != 0 || sb12.size() != 0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (sb8.size() != 0 || sb12.size() != 0) bad("drain_timeout");
  endtask

  always @(negedge clk) begin
    if (ov8) begin
      if (sb8.size() == 0) bad("unexpected_out_valid8");
      else begin
        e8 = sb8.pop_front();
        chk("q8", int'($signed(q8)), e8.q);
        chk("r8", int'($signed(r8)), e8.r);
        chk("dbz8", int'(dz8), int'(e8.dz));
        chk("ovf8", int'(of8), int'(e8.of));
        chk("lat8", cyc - e8.acc, e8.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (ov12) begin
      if (sb12.size() == 0) bad("unexpected_out_valid12");
      else begin
        e12 = sb12.pop_front();
        chk("q12", int'($signed(q12)), e12.q);
        chk("r12", int'($signed(r12)), e12.r);
        chk("dbz12", int'(dz12), int'(e12.dz));
        chk("ovf12", int'(of12), int'(e12.of));
        chk("lat12", cyc - e12.acc, e12.lat);
      end
    end
  end

  initial begin
    exp_t m;
    int   a, b, n;
    bit   was_rdy;

    reset = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0;
    v12 = 1'b0; a12 = '0; b12 = '0;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(ov8), 0);
    chk("rst_q", int'(q8), 0);
    chk("rst_r", int'(r8), 0);
    chk("rst_dbz", int'(dz8), 0);
    chk("rst_ovf", int'(of8), 0);
    chk("rst_in_ready", int'(rdy8), 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Sign combinations, back to back
    issue(8, 100, 7, 14, 2, 0, 0);
    issue(8, -100, 7, -14, -2, 0, 0);
    issue(8, 100, -7, -14, 2, 0, 0);
    issue(8, -100, -7, 14, -2, 0, 0);
    // Special paths and magnitude boundaries
    issue(8, -128, -1, -128, 0, 0, 1);
    issue(8, 5, 0, -1, 0, 1, 0);
    issue(8, -128, 1, -128, 0, 0, 0);
    issue(8, -128, -128, 1, 0, 0, 0);
    issue(8, 127, -128, 0, 127, 0, 0);
    issue(8, -7, 100, 0, -7, 0, 0);
    issue(12, -2047, -32, 63, -31, 0, 0);
    issue(12, 2047, 31, 66, 1, 0, 0);
    issue(12, 0, -5, 0, 0, 0, 0);
    issue(12, -2048, -1, -2048, 0, 0, 1);
    drain();

    // in_valid held high: only operands present while ready are taken
    v8 = 1'b1;
    for (int i = 0; i < 35; i++) begin
      a = ((i * 37) % 256) - 128;
      b = (i % 9) - 4;
      if (b == 0) b = 3;
      a8 = a[7:0]; b8 = b[7:0];
      was_rdy = rdy8;
      @(posedge clk); #1;
      if (was_rdy) begin
        m = model(a, b, 8);
        m.acc = cyc;
        m.lat = 9;
        sb8.push_back(m);
      end
    end
    v8 = 1'b0;
    drain();

    // Reset four cycles into a division aborts it
    issue(8, 100, 7, 14, 2, 0, 0);
    drain();
    n = 0;
    while (!rdy8 && n < 50) begin @(posedge clk); #1; n++; end
    a8 = 8'd100; b8 = 8'd7; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort_q", int'(q8), 0);
    chk("abort_r", int'(r8), 0);
    chk("abort_out_valid", int'(ov8), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", int'(rdy8), 1);
    repeat (15) begin @(posedge clk); #1; end
    issue(8, 100, 7, 14, 2, 0, 0);
    drain();

    // Signed sweeps against a behavioural reference
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 255) - 128;
      b = $urandom_range(0, 255) - 128;
      m = model(a, b, 8);
      issue(8, a, b, m.q, m.r, m.dz, m.of);
    end
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 4095) - 2048;
      b = $urandom_range(0, 63) - 32;
      m = model(a, b, 12);
      issue(12, a, b, m.q, m.r, m.dz, m.of);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
